lfsr_encrypt: RTL and testbench
===============================

# lfsr_encrypt

Programmable message encryptor for the Lab 4/5 data-path pair. Reads a plaintext message and three configuration bytes from its internal 128-byte data memory. Builds a 64-byte frame: underscore preamble, then message, then underscore fill. XORs each frame byte with a 6-bit maximal-length LFSR stream and writes the 64-byte ciphertext to the upper half of memory, ready for the decryption block.

## Interface
- Parameters: none. Frame length fixed at 64; message field fixed at 50 bytes; memory fixed at 128 x 8.
- Clock and reset: one clock; reset is synchronous and active-high. The ports are named as below.
- clk  input  1  system clock; all state changes on the rising edge.
- init  input  1  synchronous active-high reset/start. While high the block idles. The first rising edge with init low starts a run.
- done  output  1  high once all 64 ciphertext bytes are written. Held until init rises.
- lfsr_state  output  6  current LFSR value (debug).
- Internal storage: array core[0:127] of 8 bits. The bench preloads it hierarchically while init is high.

## Operation
- Memory map, inputs:
  - core[0..49]: plaintext. Unused bytes are 0x5f.
  - core[61]: pre_length.
  - core[62]: pat_sel.
  - core[63]: LFSR start value, low 6 bits.
- Memory map, outputs: core[64..127] receive ciphertext bytes 0..63. core[0..63] are never written.
- Config sanitising, applied at latch:
  - pre_length < 7 becomes 8.
  - pre_length > 63 becomes 63.
  - pat_sel > 5 becomes 3.
  - LFSR start 0 becomes 6'h01.
- Tap table by pat_sel 0..5: 6'h21, 6'h2D, 6'h30, 6'h33, 6'h36, 6'h39.
- LFSR step: next = {lfsr[4:0], ^(lfsr & taps)}. lfsr[0] is the sanitised start value.
- Frame byte i (i = 0..63):
  - i < pre_length: 0x5f.
  - otherwise, if i - pre_length < 50: core[i - pre_length].
  - otherwise: 0x5f.
- Cipher byte i = frame[i] ^ {2'b00, lfsr[i]}. The upper two bits pass through unchanged.
- States:
  - IDLE: entered while init is high; exits to RUN on the first edge with init low.
  - RUN: 64 cycles; exits to DONE.
  - DONE: holds until init goes high.
- IDLE to RUN edge: latch sanitised config; lfsr <= start; cnt <= 0.
- RUN, each edge:
  - core[64+cnt] <= cipher byte.
  - lfsr <= next.
  - cnt <= cnt + 1 (6-bit).
  - On the edge where cnt = 63: write the final byte, then go to DONE.
- DONE: no memory writes; lfsr and cnt frozen.
- Reads of core are combinational, so there is no read latency.

## Timing
- Reset values, with init high at an edge: state IDLE, done 0, cnt 0, lfsr_state 0. core is not cleared.
- Edge E0 is the first edge with init low: config is latched and state becomes RUN.
- Edges E1..E64 write core[64]..core[127] respectively.
- After E64, done = 1. Total: 65 edges from init falling to done.
- Config or plaintext writes to core during RUN are undefined. The config is never re-read after E0.
- init rising mid-RUN: at the next edge the block aborts to IDLE and done = 0. Bytes already written remain in memory. The next init fall restarts from byte 0.
- init high during DONE: done falls at that edge.
- A frame with pre_length + 50 > 64 truncates the message tail. This is not an error.

## Test plan
- Nominal run. Load "Mr_Watson_come_here_I_want_to_see_you", pre_length 10, pat_sel 2, start 6'h01. Required:
  - core[64] = 0x5e and core[65] = 0x5d.
  - core[74] = 0x7c ('M' ^ 6'h31).
  - done rises exactly 65 edges after init falls.
- Round trip. For all 6 tap patterns and random nonzero starts, compare core[64..127] against a bench model of the same algorithm, byte for byte.
- Sanitising:
  - pre_length 3 gives frame bytes 0..7 = 0x5f and message starting at byte 8.
  - pat_sel 7 behaves as 3 (taps 6'h33).
  - start 0 behaves as 1, so core[64] = 0x5e.
- Long preamble. pre_length 63: core[64..126] are 0x5f ^ lfsr. core[127] = core[0] ^ lfsr[63].
- Abort mid-run. Raise init at E20 for 1 cycle, then drop it. Required: done stays 0 until 65 edges after the second fall, and the final contents match the nominal run.
- Done hold. Keep init low for 100 cycles after done. Required: done stays 1, lfsr_state is unchanged, and core[64..127] are unchanged.

Source files
------------

// File: rtl/lfsr_encrypt.sv
// Frame encryptor: builds a 64-byte frame (preamble, message, fill) from core[0..63]
// and writes it XORed with a 6-bit LFSR stream into core[64..127].
module lfsr_encrypt (
  input  logic       clk,
  input  logic       init,
  output logic       done,
  output logic [5:0] lfsr_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [5:0] cnt_q, cnt_d;
  logic [5:0] lfsr_q, lfsr_d;
  logic [5:0] taps_q, taps_d;
  logic [5:0] pre_q, pre_d;

  logic [7:0] core [0:127];

  logic [7:0] raw_pre;
  logic [7:0] raw_sel;
  logic [7:0] raw_start;
  logic [5:0] pre_san;
  logic [2:0] sel_san;
  logic [5:0] taps_san;
  logic [5:0] start_san;
  logic [5:0] msg_off;
  logic [7:0] frame_byte;
  logic [7:0] cipher_byte;
  logic       wr_en;

  // Configuration sanitising, only consumed on the IDLE -> RUN edge.
  always_comb begin
    raw_pre   = core[61];
    raw_sel   = core[62];
    raw_start = core[63];
    if (raw_pre < 8'd7) begin
      pre_san = 6'd8;
    end else if (raw_pre > 8'd63) begin
      pre_san = 6'd63;
    end else begin
      pre_san = raw_pre[5:0];
    end
    if (raw_sel > 8'd5) begin
      sel_san = 3'd3;
    end else begin
      sel_san = raw_sel[2:0];
    end
    case (sel_san)
      3'd0:    taps_san = 6'h21;
      3'd1:    taps_san = 6'h2D;
      3'd2:    taps_san = 6'h30;
      3'd3:    taps_san = 6'h33;
      3'd4:    taps_san = 6'h36;
      default: taps_san = 6'h39;
    endcase
    start_san = (raw_start[5:0] == 6'd0) ? 6'h01 : raw_start[5:0];
  end

  // Frame byte for the current count; the offset wraps harmlessly when cnt < pre.
  always_comb begin
    msg_off = cnt_q - pre_q;
    if (cnt_q < pre_q) begin
      frame_byte = 8'h5f;
    end else if (msg_off < 6'd50) begin
      frame_byte = core[{1'b0, msg_off}];
    end else begin
      frame_byte = 8'h5f;
    end
    cipher_byte = frame_byte ^ {2'b00, lfsr_q};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lfsr_d  = lfsr_q;
    taps_d  = taps_q;
    pre_d   = pre_q;
    wr_en   = 1'b0;
    case (state_q)
      IDLE: begin
        state_d = RUN;
        pre_d   = pre_san;
        taps_d  = taps_san;
        lfsr_d  = start_san;
        cnt_d   = 6'd0;
      end
      RUN: begin
        wr_en  = 1'b1;
        lfsr_d = {lfsr_q[4:0], ^(lfsr_q & taps_q)};
        cnt_d  = cnt_q + 6'd1;
        if (cnt_q == 6'd63) begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = DONE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (init) begin
      state_q <= IDLE;
      cnt_q   <= 6'd0;
      lfsr_q  <= 6'd0;
      taps_q  <= 6'd0;
      pre_q   <= 6'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lfsr_q  <= lfsr_d;
      taps_q  <= taps_d;
      pre_q   <= pre_d;
    end
  end

  // Ciphertext lands in the upper half only; the lower half is never written.
  always_ff @(posedge clk) begin
    if (!init && wr_en) begin
      core[{1'b1, cnt_q}] <= cipher_byte;
    end
  end

  assign done       = (state_q == DONE);
  assign lfsr_state = lfsr_q;

endmodule

// File: tb/tb_lfsr_encrypt.sv
// Bench for lfsr_encrypt: reference model fills an expected-byte queue per run,
// a monitor pops and compares core[64..127] when done rises.
module tb_lfsr_encrypt;

  logic       clk = 1'b0;
  logic       init = 1'b1;
  logic       done;
  logic [5:0] lfsr_state;

  int tests_run = 0;
  int fails = 0;

  logic [7:0] exp_q[$];
  logic [7:0] img [0:63];
  logic [5:0] tap_tbl [0:5];
  logic       mon_done_d = 1'b0;

  lfsr_encrypt dut (
    .clk        (clk),
    .init       (init),
    .done       (done),
    .lfsr_state (lfsr_state)
  );

  always #5 clk = ~clk;

  initial begin
    tap_tbl[0] = 6'h21; tap_tbl[1] = 6'h2D; tap_tbl[2] = 6'h30;
    tap_tbl[3] = 6'h33; tap_tbl[4] = 6'h36; tap_tbl[5] = 6'h39;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: on each rising done, the 64 ciphertext bytes are the DUT's output.
  always @(negedge clk) begin
    if (done && !mon_done_d) begin
      for (int i = 0; i < 64; i++) begin
        if (exp_q.size() == 0) begin
          check("sb_underflow", i, 64);
          break;
        end
        check($sformatf("cipher[%0d]", i), dut.core[64+i], exp_q.pop_front());
      end
    end
    mon_done_d = done;
  end

  // Reference model straight from the frame/cipher rules.
  task automatic push_expected();
    int pre, sel, par;
    logic [5:0] taps, lf;
    logic [7:0] fr;
    pre = int'(img[61]);
    if (pre < 7) pre = 8;
    else if (pre > 63) pre = 63;
    sel = int'(img[62]);
    if (sel > 5) sel = 3;
    taps = tap_tbl[sel];
    lf = img[63][5:0];
    if (lf == 6'd0) lf = 6'd1;
    for (int i = 0; i < 64; i++) begin
      if (i < pre) fr = 8'h5f;
      else if (i - pre < 50) fr = img[i-pre];
      else fr = 8'h5f;
      exp_q.push_back(fr ^ {2'b00, lf});
      par = $countones(lf & taps) % 2;
      lf = 6'((int'(lf) * 2) % 64 + par);
    end
  endtask

  // Preload while init is high; bytes 50..60 are junk the frame must never use.
  task automatic setup(input logic [7:0] pre, input logic [7:0] sel, input logic [7:0] start);
    for (int i = 50; i < 61; i++) img[i] = 8'($urandom_range(0, 255));
    img[61] = pre;
    img[62] = sel;
    img[63] = start;
    for (int i = 0; i < 64; i++) begin
      dut.core[i]    = img[i];
      dut.core[64+i] = 8'h00;
    end
  endtask

  task automatic fill_msg(input string msg);
    for (int i = 0; i < 50; i++) img[i] = (i < msg.len()) ? msg[i] : 8'h5f;
  endtask

  task automatic fill_random();
    for (int i = 0; i < 50; i++) img[i] = 8'($urandom_range(0, 255));
  endtask

  // Called just after a clock edge; returns edges from init falling to done.
  task automatic run_frame(output int lat);
    init = 1'b0;
    lat = -1;
    for (int n = 1; n <= 200; n++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = n;
        break;
      end
    end
    if (lat < 0) check("done_timeout", 0, 1);
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic go_idle();
    init = 1'b1;
    @(posedge clk); #1;
    check("idle_done_low", done, 0);
  endtask

  task automatic start_edge();
    @(posedge clk); #1;
  endtask

  int lat;
  int bad;
  logic [5:0] lf_snap;
  logic [7:0] snap [0:63];
  logic       hold_ok;

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("reset_done", done, 0);
    check("reset_lfsr", lfsr_state, 0);

    // Nominal run
    fill_msg("Mr_Watson_come_here_I_want_to_see_you");
    setup(8'd10, 8'd2, 8'h01);
    push_expected();
    start_edge();
    run_frame(lat);
    check("nom_latency", lat, 65);
    check("nom_core64", dut.core[64], 8'h5e);
    check("nom_core65", dut.core[65], 8'h5d);
    check("nom_core74", dut.core[74], 8'h7c);

    // Done hold
    lf_snap = lfsr_state;
    for (int i = 0; i < 64; i++) snap[i] = dut.core[64+i];
    hold_ok = 1'b1;
    for (int n = 0; n < 100; n++) begin
      @(posedge clk); #1;
      if (!done) hold_ok = 1'b0;
    end
    check("hold_done", hold_ok, 1);
    check("hold_lfsr", lfsr_state, lf_snap);
    bad = 0;
    for (int i = 0; i < 64; i++) if (dut.core[64+i] !== snap[i]) bad++;
    check("hold_mem", bad, 0);
    go_idle();

    // Round trip over all tap patterns, random starts, random raw pre_length
    for (int s = 0; s < 6; s++) begin
      for (int r = 0; r < 2; r++) begin
        fill_random();
        setup(8'($urandom_range(0, 80)), 8'(s), 8'($urandom_range(1, 63)));
        push_expected();
        start_edge();
        run_frame(lat);
        check("rt_latency", lat, 65);
        go_idle();
      end
    end

    // Sanitising: short preamble, out-of-range pattern, zero start
    fill_random();
    setup(8'd3, 8'd7, 8'h00);
    push_expected();
    start_edge();
    run_frame(lat);
    check("san_core64", dut.core[64], 8'h5e);
    go_idle();

    // Long preamble: last byte carries core[0]
    fill_random();
    setup(8'd63, 8'($urandom_range(0, 5)), 8'($urandom_range(1, 63)));
    push_expected();
    start_edge();
    run_frame(lat);
    check("long_core127_hi", {24'd0, dut.core[127] & 8'hc0}, {24'd0, img[0] & 8'hc0});
    go_idle();

    // Abort mid-run at E20, then restart
    fill_msg("Mr_Watson_come_here_I_want_to_see_you");
    setup(8'd10, 8'd2, 8'h01);
    push_expected();
    start_edge();
    init = 1'b0;
    repeat (21) @(posedge clk);
    #1;
    init = 1'b1;
    @(posedge clk); #1;
    check("abort_done_low", done, 0);
    run_frame(lat);
    check("abort_latency", lat, 65);
    check("abort_core74", dut.core[74], 8'h7c);
    go_idle();

    check("sb_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
